// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with checkpoint restore
module ras_stack #(
  parameter int RAS_ENTRIES      = 8,
  parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] link_target,
  input  logic                        ret_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target,
  output logic [LOG_RAS_ENTRIES-1:0]  ras_index,
  output logic [LOG_RAS_ENTRIES:0]    ras_count,
  output logic                        ras_empty,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  restore_index,
  input  logic [LOG_RAS_ENTRIES:0]    restore_count
);

  localparam logic [LOG_RAS_ENTRIES:0]   MAX_COUNT = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ONE   = 1;
  localparam logic [LOG_RAS_ENTRIES-1:0] PTR_ONE   = 1;

  logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  ptr_q, ptr_d;
  logic [LOG_RAS_ENTRIES:0]    count_q, count_d;
  logic                        wr_en;
  logic [LOG_RAS_ENTRIES-1:0]  wr_idx;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (restore_valid) begin
      ptr_d   = restore_index;
      count_d = (restore_count > MAX_COUNT) ? MAX_COUNT : restore_count;
    end else if (link_valid && ret_valid) begin
      // Call and return together replace the top entry in place.
      wr_en = 1'b1;
      if (count_q == '0) count_d = CNT_ONE;
    end else if (link_valid) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q + PTR_ONE;
      ptr_d  = ptr_q + PTR_ONE;
      if (count_q != MAX_COUNT) count_d = count_q + CNT_ONE;
    end else if (ret_valid && (count_q != '0)) begin
      ptr_d   = ptr_q - PTR_ONE;
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) entry_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (wr_en) entry_q[wr_idx] <= link_target;
    end
  end

  assign ret_target = entry_q[ptr_q];
  assign ras_index  = ptr_q;
  assign ras_count  = count_q;
  assign ras_empty  = (count_q == '0);

endmodule
